// File: rtl/rr_index_arbiter.sv
// 32-requester round-robin arbiter producing a registered index/enable pair
// for a 5-to-32 decoder; a rotating pointer gives each requester fair turns.
module rr_index_arbiter #(
    parameter int unsigned N_REQ = 32,
    parameter int unsigned IDX_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             arb_en,
    input  logic [N_REQ-1:0] req,
    input  logic             ack,
    output logic [IDX_W-1:0] idx,
    output logic             enable,
    output logic [IDX_W-1:0] ptr
);

    typedef enum logic {
        StIdle,
        StGrant
    } state_e;

    state_e           state_q;
    logic [IDX_W-1:0] winner;
    logic             found;

    // Scan from ptr upward; the index wraps naturally at IDX_W bits.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            logic [IDX_W-1:0] cand;
            cand = ptr + IDX_W'(i);
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx     <= '0;
            enable  <= 1'b0;
            ptr     <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (arb_en && found) begin
                        state_q <= StGrant;
                        enable  <= 1'b1;
                        idx     <= winner;
                        ptr     <= winner + IDX_W'(1);
                    end
                end
                StGrant: begin
                    if (!arb_en) begin
                        // Abandon the grant; ptr keeps its advanced value.
                        state_q <= StIdle;
                        enable  <= 1'b0;
                    end else if (ack) begin
                        if (found) begin
                            idx <= winner;
                            ptr <= winner + IDX_W'(1);
                        end else begin
                            state_q <= StIdle;
                            enable  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    enable  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_index_arbiter.sv
// Self-checking bench for rr_index_arbiter: directed vector table, hand-written
// corner sequences, and randomized traffic against a behavioural model.
module tb_rr_index_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        arb_en;
    logic [31:0] req;
    logic        ack;
    logic [4:0]  idx;
    logic        enable;
    logic [4:0]  ptr;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit m_en;
    int m_idx;
    int m_ptr;

    rr_index_arbiter dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .arb_en (arb_en),
        .req    (req),
        .ack    (ack),
        .idx    (idx),
        .enable (enable),
        .ptr    (ptr)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        r;
        bit        a;
        bit        k;
        bit [31:0] q;
        int        e_idx;
        bit        e_en;
        int        e_ptr;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int first_from(input int start, input bit [31:0] q);
        for (int k = 0; k < 32; k++) begin
            if (q[(start + k) % 32]) return (start + k) % 32;
        end
        return -1;
    endfunction

    task automatic model_step();
        int w;
        w = first_from(m_ptr, req);
        if (!rst_n) begin
            m_en = 0; m_idx = 0; m_ptr = 0;
        end else if (!m_en) begin
            if (arb_en && w >= 0) begin
                m_en = 1; m_idx = w; m_ptr = (w + 1) % 32;
            end
        end else if (!arb_en) begin
            m_en = 0;
        end else if (ack) begin
            if (w >= 0) begin
                m_idx = w; m_ptr = (w + 1) % 32;
            end else begin
                m_en = 0;
            end
        end
    endtask

    task automatic drive(input bit r, input bit a, input bit k, input bit [31:0] q);
        rst_n  = r;
        arb_en = a;
        ack    = k;
        req    = q;
        model_step();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[$];

    initial begin
        rst_n = 1'b0; arb_en = 1'b0; ack = 1'b0; req = '0;
        m_en = 0; m_idx = 0; m_ptr = 0;

        // {rst_n, arb_en, ack, req, idx, enable, ptr}
        vecs.push_back('{0, 0, 0, 32'h0000_0000,  0, 0,  0});
        vecs.push_back('{0, 1, 0, 32'h0000_0001,  0, 0,  0});
        vecs.push_back('{1, 1, 0, 32'h0000_0001,  0, 1,  1});
        vecs.push_back('{1, 1, 1, 32'h0000_0088,  3, 1,  4});
        vecs.push_back('{1, 1, 1, 32'h0000_0088,  7, 1,  8});
        vecs.push_back('{1, 1, 1, 32'h0000_0088,  3, 1,  4});
        vecs.push_back('{1, 1, 1, 32'h0000_0088,  7, 1,  8});
        vecs.push_back('{1, 1, 0, 32'h0000_0400,  7, 1,  8});
        vecs.push_back('{1, 1, 1, 32'h0000_0400, 10, 1, 11});
        vecs.push_back('{1, 1, 1, 32'h0000_0000, 10, 0, 11});
        vecs.push_back('{1, 0, 0, 32'h0000_1000, 10, 0, 11});
        vecs.push_back('{1, 1, 0, 32'h0000_1000, 12, 1, 13});
        vecs.push_back('{1, 0, 1, 32'h0000_1000, 12, 0, 13});
        vecs.push_back('{1, 1, 0, 32'h4000_0000, 30, 1, 31});
        vecs.push_back('{1, 1, 1, 32'h8000_0001, 31, 1,  0});
        vecs.push_back('{1, 1, 1, 32'h8000_0001,  0, 1,  1});
        vecs.push_back('{1, 1, 0, 32'h0000_0020,  0, 1,  1});
        vecs.push_back('{1, 1, 1, 32'h0000_0020,  5, 1,  6});
        vecs.push_back('{1, 1, 1, 32'h0000_0000,  5, 0,  6});
        vecs.push_back('{1, 1, 0, 32'h0000_1000, 12, 1, 13});
        vecs.push_back('{0, 1, 0, 32'h0000_1000,  0, 0,  0});

        foreach (vecs[i]) begin
            drive(vecs[i].r, vecs[i].a, vecs[i].k, vecs[i].q);
            chk($sformatf("vec%0d_idx", i), int'(idx), vecs[i].e_idx);
            chk($sformatf("vec%0d_en", i), int'(enable), int'(vecs[i].e_en));
            chk($sformatf("vec%0d_ptr", i), int'(ptr), vecs[i].e_ptr);
        end

        // Hold: grant 5, then 5 cycles without ack while req moves to bit 10.
        drive(0, 0, 0, 32'h0);
        drive(1, 1, 0, 32'h0000_0020);
        chk("hold_grant_idx", int'(idx), 5);
        for (int c = 0; c < 5; c++) begin
            drive(1, 1, 0, 32'h0000_0400);
            chk("hold_idx", int'(idx), 5);
            chk("hold_en", int'(enable), 1);
        end
        drive(1, 1, 1, 32'h0000_0400);
        chk("hold_next_idx", int'(idx), 10);

        // Reset in the middle of a grant, no ack.
        drive(1, 1, 0, 32'h0000_0400);
        drive(0, 1, 0, 32'h0000_0400);
        chk("rst_mid_idx", int'(idx), 0);
        chk("rst_mid_en", int'(enable), 0);
        chk("rst_mid_ptr", int'(ptr), 0);

        // Full load: 64 accepted grants count 0..31 twice.
        begin
            int hits[32];
            foreach (hits[j]) hits[j] = 0;
            for (int c = 0; c < 64; c++) begin
                drive(1, 1, 1, 32'hFFFF_FFFF);
                chk("full_idx", int'(idx), c % 32);
                chk("full_en", int'(enable), 1);
                hits[idx]++;
            end
            foreach (hits[j]) chk($sformatf("full_hits%0d", j), hits[j], 2);
        end

        // Randomized traffic against the model.
        drive(0, 0, 0, 32'h0);
        for (int c = 0; c < 3000; c++) begin
            bit        r, a, k;
            bit [31:0] q;
            int        sel;
            r   = ($urandom_range(0, 99) != 0);
            a   = ($urandom_range(0, 9) != 0);
            k   = $urandom_range(0, 1) != 0;
            sel = $urandom_range(0, 3);
            case (sel)
                0: q = 32'h0;
                1: q = 32'h1 << $urandom_range(0, 31);
                2: q = $urandom() & $urandom() & $urandom();
                default: q = $urandom();
            endcase
            drive(r, a, k, q);
            chk("rand_en", int'(enable), int'(m_en));
            chk("rand_idx", int'(idx), m_idx);
            chk("rand_ptr", int'(ptr), m_ptr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
